// File: rtl/dac_spi_serializer_pkg.sv
// rtl/dac_spi_serializer_pkg.sv - shared constants and helpers for the DAC SPI serializer
package dac_spi_serializer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam int FRAME_BITS       = 16;
    localparam int DAC_BITS_DEFAULT = 12;

    // Busy cycles per frame: 32 sclk half-periods plus one half-period gap.
    // A sample period must exceed this by at least one cycle to avoid overruns.
    function automatic int frame_cycles(input int clk_div);
        return 33 * clk_div;
    endfunction

    // Clamp an unsigned waveform word to the DAC full-scale code.
    function automatic logic [FRAME_BITS-1:0] saturate(input logic [FRAME_BITS-1:0] s,
                                                       input int dac_bits);
        logic [FRAME_BITS-1:0] maxv;
        maxv = FRAME_BITS'((32'd1 << dac_bits) - 32'd1);
        return (s > maxv) ? maxv : s;
    endfunction

endpackage

// File: rtl/dac_tick_gen.sv
// rtl/dac_tick_gen.sv - enable-gated modulo-SAMPLE_DIV counter emitting a one-cycle tick
module dac_tick_gen #(
    parameter int SAMPLE_DIV = 2000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    output logic tick
);

    localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

    logic [CW-1:0] cnt;

    // Count while enabled, wrap at SAMPLE_DIV-1; dropping ena restarts the period.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!ena || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = ena && (cnt == LAST);

endmodule

// File: rtl/dac_spi_serializer.sv
// rtl/dac_spi_serializer.sv - paced saturating serializer into a 12-bit SPI DAC
module dac_spi_serializer
    import dac_spi_serializer_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int SAMPLE_DIV = 2000,
    parameter int DAC_BITS   = DAC_BITS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic [15:0] sample,
    output logic        sclk,
    output logic        sync_n,
    output logic        sdata,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic                  tick;
    logic [1:0]            state;
    logic [DW-1:0]         div_cnt;
    logic [3:0]            bit_cnt;
    logic [FRAME_BITS-1:0] shreg;
    logic [FRAME_BITS-1:0] word;

    dac_tick_gen #(
        .SAMPLE_DIV(SAMPLE_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .ena  (ena),
        .tick (tick)
    );

    assign word = saturate(sample, DAC_BITS);

    // Frame FSM: latch on tick, shift on sclk rising edges, then a half-period gap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            sclk       <= 1'b1;
            sync_n     <= 1'b1;
            sdata      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // Any tick outside IDLE is dropped, including on the cycle GAP exits.
            overrun    <= tick && (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (tick) begin
                        shreg   <= word;
                        sdata   <= word[FRAME_BITS-1];
                        sync_n  <= 1'b0;
                        busy    <= 1'b1;
                        bit_cnt <= 4'd15;
                        div_cnt <= '0;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        sclk    <= ~sclk;
                        // Data only moves on the rising edge; the DAC samples on the falling one.
                        if (!sclk) begin
                            if (bit_cnt != 4'd0) begin
                                shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
                                sdata   <= shreg[FRAME_BITS-2];
                                bit_cnt <= bit_cnt - 4'd1;
                            end else begin
                                sync_n     <= 1'b1;
                                frame_done <= 1'b1;
                                state      <= ST_GAP;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
